// File: rtl/rv_trap_csr_unit_if.sv
// rv_trap_csr_unit_if: core-side CSR access, trap event and interrupt status bundle
interface rv_trap_csr_unit_if;
  logic        csr_req_i;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wsrc_i;
  logic        csr_wsrc_zero_i;
  logic        csr_rd_zero_i;
  logic        csr_ack_o;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic        irq_take_i;
  logic [31:0] trap_pc_i;
  logic        retire_i;
  logic        irq_req_o;
  logic        wfi_wake_o;
  logic        trap_valid_o;
  logic [31:0] trap_vec_o;
  logic [31:0] mip_o;
  logic [31:0] mie_o;
  modport master (
    output csr_req_i, csr_op_i, csr_addr_i, csr_wsrc_i, csr_wsrc_zero_i, csr_rd_zero_i,
    output ecall_i, ebreak_i, mret_i, irq_take_i, trap_pc_i, retire_i,
    input  csr_ack_o, csr_rdata_o, csr_illegal_o, irq_req_o, wfi_wake_o,
    input  trap_valid_o, trap_vec_o, mip_o, mie_o
  );
  modport slave (
    input  csr_req_i, csr_op_i, csr_addr_i, csr_wsrc_i, csr_wsrc_zero_i, csr_rd_zero_i,
    input  ecall_i, ebreak_i, mret_i, irq_take_i, trap_pc_i, retire_i,
    output csr_ack_o, csr_rdata_o, csr_illegal_o, irq_req_o, wfi_wake_o,
    output trap_valid_o, trap_vec_o, mip_o, mie_o
  );
endinterface

// File: rtl/rv_trap_csr_unit.sv
// rv_trap_csr_unit: machine-mode CSR file, counters and trap/interrupt controller
module rv_trap_csr_unit #(
  parameter int          NUM_IRQ       = 8,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000,
  parameter logic [31:0] RESET_MTVEC   = 32'h08001000,
  parameter int          COUNTER_EN    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  rv_trap_csr_unit_if.slave  bus
);
  localparam logic [31:0]        MIE_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
  localparam logic [NUM_IRQ-1:0] EDGE     = IRQ_EDGE_MASK[NUM_IRQ-1:0];
  localparam bit                 CNT      = COUNTER_EN != 0;
  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q, pend_q, pend_d, lines, act, clr;
  logic               mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [31:0]        mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d, mscratch_q, mscratch_d;
  logic [63:0]        mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0]        mip, mstatus, base, old, wdata, rdata_d, rdata_q, vec_d, vec_q;
  logic               ack_q, ill_q, ill_d, trap_q, trap_d, irq_req, known, is_cnt;
  logic               op_rw, op_rs, op_rc, wr_try, we;
  logic               take, ecall_e, ebrk_e, mret_e, csr_e;
  logic [4:0]         idx;
  assign lines   = (EDGE & pend_q) | (~EDGE & s2_q);
  assign mip     = 32'(lines) << 16;
  assign act     = lines & mie_q[16 +: NUM_IRQ];
  assign irq_req = mst_mie_q & |act;
  assign mstatus = {19'h0, 2'b11, 3'h0, mst_mpie_q, 3'h0, mst_mie_q, 3'h0};
  assign base    = {mtvec_q[31:2], 2'b00};
  assign take    = bus.irq_take_i & irq_req;
  assign ecall_e = ~take & bus.ecall_i;
  assign ebrk_e  = ~take & ~bus.ecall_i & bus.ebreak_i;
  assign mret_e  = ~take & ~bus.ecall_i & ~bus.ebreak_i & bus.mret_i;
  assign csr_e   = bus.csr_req_i & ~(take | bus.ecall_i | bus.ebreak_i | bus.mret_i);
  assign bus.csr_ack_o     = ack_q;
  assign bus.csr_rdata_o   = rdata_q;
  assign bus.csr_illegal_o = ill_q;
  assign bus.trap_valid_o  = trap_q;
  assign bus.trap_vec_o    = vec_q;
  assign bus.irq_req_o     = irq_req;
  assign bus.wfi_wake_o    = |act;
  assign bus.mip_o         = mip;
  assign bus.mie_o         = mie_q;
  // lowest-numbered pending and enabled line is the one taken
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (act[i]) idx = 5'(i);
  end
  // CSR read mux, access legality and write-data formation
  always_comb begin
    old   = '0;
    known = 1'b1;
    case (bus.csr_addr_i)
      12'h300: old = mstatus;
      12'h304: old = mie_q;
      12'h344: old = mip;
      12'h305: old = mtvec_q;
      12'h341: old = mepc_q;
      12'h342: old = mcause_q;
      12'h340: old = mscratch_q;
      12'hB00: old = mcycle_q[31:0];
      12'hB80: old = mcycle_q[63:32];
      12'hB02: old = minstret_q[31:0];
      12'hB82: old = minstret_q[63:32];
      12'hF14: old = '0;
      default: known = 1'b0;
    endcase
    is_cnt  = bus.csr_addr_i inside {12'hB00, 12'hB80, 12'hB02, 12'hB82};
    op_rw   = bus.csr_op_i == 3'd1 || bus.csr_op_i == 3'd5;
    op_rs   = bus.csr_op_i == 3'd2 || bus.csr_op_i == 3'd6;
    op_rc   = bus.csr_op_i == 3'd3 || bus.csr_op_i == 3'd7;
    wr_try  = op_rw | ~bus.csr_wsrc_zero_i;
    ill_d   = ~known | ~(op_rw | op_rs | op_rc) |
              (wr_try & ((bus.csr_addr_i == 12'hF14) | (is_cnt & !CNT)));
    we      = csr_e & wr_try & ~ill_d;
    wdata   = op_rw ? bus.csr_wsrc_i : op_rs ? old | bus.csr_wsrc_i : old & ~bus.csr_wsrc_i;
    rdata_d = (ill_d | (op_rw & bus.csr_rd_zero_i)) ? '0 : old;
  end
  // next-state for CSRs, counters, pending bits and the trap redirect
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mcycle_d   = CNT ? mcycle_q + 64'd1 : '0;
    minstret_d = CNT ? minstret_q + 64'(bus.retire_i) : '0;
    clr        = '0;
    if (we) begin
      case (bus.csr_addr_i)
        12'h300: begin
          mst_mie_d  = wdata[3];
          mst_mpie_d = wdata[7];
        end
        12'h304: mie_d      = wdata & MIE_MASK;
        12'h344: clr        = ~wdata[16 +: NUM_IRQ];
        12'h305: mtvec_d    = {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
        12'h341: mepc_d     = wdata & ~32'h3;
        12'h342: mcause_d   = wdata;
        12'h340: mscratch_d = wdata;
        12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
        12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wdata};
        12'hB82: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (take | ecall_e | ebrk_e) begin
      mepc_d     = bus.trap_pc_i & ~32'h3;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mcause_d   = take ? {1'b1, 31'(idx) + 31'd16} : ecall_e ? 32'd11 : 32'd3;
    end
    if (take) clr = clr | (NUM_IRQ'(1) << idx);
    if (mret_e) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
    pend_d = EDGE & ((s2_q & ~s3_q) | (pend_q & ~clr));
    trap_d = take | ecall_e | ebrk_e | mret_e;
    vec_d  = take ? (mtvec_q[1:0] == 2'b01 ? base + ((32'(idx) + 32'd16) << 2) : base) :
             mret_e ? mepc_q : base;
  end
  // state registers; reset also cancels any in-flight ack or trap pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      pend_q     <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      ack_q      <= 1'b0;
      ill_q      <= 1'b0;
      rdata_q    <= '0;
      trap_q     <= 1'b0;
      vec_q      <= RESET_MTVEC;
    end else begin
      s1_q       <= irq_i;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      pend_q     <= pend_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      ack_q      <= csr_e;
      ill_q      <= csr_e & ill_d;
      rdata_q    <= csr_e ? rdata_d : '0;
      trap_q     <= trap_d;
      if (trap_d) vec_q <= vec_d;
    end
  end
endmodule

// File: tb/tb_rv_trap_csr_unit.sv
// tb_rv_trap_csr_unit: randomized and directed checks of the trap/CSR unit against a behavioural model
module tb_rv_trap_csr_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = '0;
  int         checks = 0;
  int         errors = 0;
  rv_trap_csr_unit_if bus();
  rv_trap_csr_unit #(
    .NUM_IRQ(8), .IRQ_EDGE_MASK(16'h0004), .RESET_MTVEC(32'h08001000), .COUNTER_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq), .bus(bus)
  );
  always #5 clk = ~clk;
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_epc, m_cause, m_scr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] w,
                     input logic wz, input logic rz, output logic [31:0] rd, output logic ill);
    bus.csr_req_i = 1'b1;
    bus.csr_op_i = op;
    bus.csr_addr_i = a;
    bus.csr_wsrc_i = w;
    bus.csr_wsrc_zero_i = wz;
    bus.csr_rd_zero_i = rz;
    @(negedge clk);
    bus.csr_req_i = 1'b0;
    check("ack", 32'(bus.csr_ack_o), 32'd1);
    rd = bus.csr_rdata_o;
    ill = bus.csr_illegal_o;
  endtask
  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic i;
    csr(3'd2, a, 32'h0, 1'b1, 1'b0, r, i);
    check(tag, r, exp);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] w);
    logic [31:0] r;
    logic i;
    csr(3'd1, a, w, w == 0, 1'b1, r, i);
  endtask
  task automatic trap(input logic t, input logic e, input logic b, input logic m, input logic [31:0] pc,
                      input logic ev, input logic [31:0] evec, input string tag);
    bus.irq_take_i = t;
    bus.ecall_i = e;
    bus.ebreak_i = b;
    bus.mret_i = m;
    bus.trap_pc_i = pc;
    @(negedge clk);
    {bus.irq_take_i, bus.ecall_i, bus.ebreak_i, bus.mret_i} = '0;
    check({tag, "_valid"}, 32'(bus.trap_valid_o), 32'(ev));
    if (ev) check({tag, "_vec"}, bus.trap_vec_o, evec);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.trap_valid_o), 32'd0);
  endtask
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      default: return m_scr;
    endcase
  endfunction
  task automatic m_write(input logic [11:0] a, input logic [31:0] w);
    case (a)
      12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
      12'h304: m_ie = w & 32'h00FF0000;
      12'h305: m_tvec = (w[1:0] >= 2) ? w & ~32'h3 : w;
      12'h341: m_epc = w & ~32'h3;
      12'h342: m_cause = w;
      default: m_scr = w;
    endcase
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [11:0] addrs[6] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
    logic [2:0]  ops[6]   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [31:0] r, w, o, exp;
    logic        ill, wz, rz, rw;
    logic [11:0] a;
    logic [2:0]  op;
    {bus.csr_req_i, bus.csr_op_i, bus.csr_addr_i, bus.csr_wsrc_i, bus.csr_wsrc_zero_i, bus.csr_rd_zero_i} = '0;
    {bus.ecall_i, bus.ebreak_i, bus.mret_i, bus.irq_take_i, bus.trap_pc_i, bus.retire_i} = '0;
    repeat (2) @(negedge clk);
    check("rst_vec", bus.trap_vec_o, 32'h08001000);
    check("rst_ack", 32'(bus.csr_ack_o), 32'd0);
    check("rst_ill", 32'(bus.csr_illegal_o), 32'd0);
    check("rst_rdata", bus.csr_rdata_o, 32'd0);
    check("rst_irq", 32'(bus.irq_req_o), 32'd0);
    check("rst_wfi", 32'(bus.wfi_wake_o), 32'd0);
    check("rst_tv", 32'(bus.trap_valid_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst_mtvec", 12'h305, 32'h08001000);
    rd_chk("rst_mstatus", 12'h300, 32'h00001800);
    rd_chk("rst_mhartid", 12'hF14, 32'h0);
    rd_chk("rst_mepc", 12'h341, 32'h0);
    m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 32'h08001000; m_epc = 0; m_cause = 0; m_scr = 0;
    for (int k = 0; k < 40; k++) begin
      a  = addrs[$urandom_range(0, 5)];
      op = ops[$urandom_range(0, 5)];
      w  = $urandom;
      if (op[2]) w = w & 32'h1F;
      if ($urandom_range(0, 3) == 0) w = 0;
      wz = w == 0;
      rz = $urandom_range(0, 3) == 0;
      rw = op[1:0] == 2'd1;
      o  = m_read(a);
      exp = (rw && rz) ? 32'h0 : o;
      if (rw || !wz) m_write(a, rw ? w : op[1:0] == 2'd2 ? o | w : o & ~w);
      csr(op, a, w, wz, rz, r, ill);
      check("rand_rdata", r, exp);
      check("rand_ill", 32'(ill), 32'd0);
    end
    foreach (addrs[i]) rd_chk("rand_final", addrs[i], m_read(addrs[i]));
    wr(12'h305, 32'h08001000);
    wr(12'h304, 32'h00010000);
    wr(12'h300, 32'h8);
    irq[0] = 1'b1;
    @(negedge clk);
    check("lvl_edge1", 32'(bus.irq_req_o), 32'd0);
    @(negedge clk);
    check("lvl_edge2", 32'(bus.irq_req_o), 32'd1);
    check("lvl_wfi", 32'(bus.wfi_wake_o), 32'd1);
    csr(3'd3, 12'h344, 32'h00010000, 1'b0, 1'b0, r, ill);
    check("mip_rdonly", bus.mip_o, 32'h00010000);
    trap(1, 0, 0, 0, 32'h08000040, 1, 32'h08001000, "take0");
    check("take0_irq", 32'(bus.irq_req_o), 32'd0);
    check("take0_wfi", 32'(bus.wfi_wake_o), 32'd1);
    rd_chk("take0_mcause", 12'h342, 32'h80000010);
    rd_chk("take0_mepc", 12'h341, 32'h08000040);
    rd_chk("take0_mstatus", 12'h300, 32'h00001880);
    irq[0] = 1'b0;
    repeat (3) @(negedge clk);
    wr(12'h305, 32'h08001001);
    wr(12'h304, 32'h00280000);
    wr(12'h300, 32'h8);
    irq[3] = 1'b1;
    irq[5] = 1'b1;
    repeat (2) @(negedge clk);
    check("vec_irq", 32'(bus.irq_req_o), 32'd1);
    trap(1, 0, 0, 0, 32'h08000100, 1, 32'h0800104C, "take_vec");
    rd_chk("vec_mcause", 12'h342, 32'h80000013);
    rd_chk("vec_mstatus", 12'h300, 32'h00001880);
    trap(0, 0, 0, 1, 32'h0, 1, 32'h08000100, "mret");
    rd_chk("mret_mstatus", 12'h300, 32'h00001888);
    check("mret_irq", 32'(bus.irq_req_o), 32'd1);
    irq[3] = 1'b0;
    repeat (3) @(negedge clk);
    trap(1, 1, 0, 0, 32'h08000200, 1, 32'h08001054, "take_ecall");
    rd_chk("coll_mcause", 12'h342, 32'h80000015);
    rd_chk("coll_mepc", 12'h341, 32'h08000200);
    trap(1, 0, 0, 0, 32'h08000250, 0, 32'h0, "take_masked");
    rd_chk("masked_mepc", 12'h341, 32'h08000200);
    trap(0, 1, 0, 0, 32'h08000300, 1, 32'h08001000, "ecall");
    rd_chk("ecall_mcause", 12'h342, 32'd11);
    rd_chk("ecall_mepc", 12'h341, 32'h08000300);
    trap(0, 0, 1, 0, 32'h08000304, 1, 32'h08001000, "ebreak");
    rd_chk("ebreak_mcause", 12'h342, 32'd3);
    trap(0, 0, 0, 1, 32'h0, 1, 32'h08000304, "mret2");
    rd_chk("mret2_mstatus", 12'h300, 32'h00001880);
    irq[5] = 1'b0;
    wr(12'h304, 32'h0);
    wr(12'h300, 32'h0);
    repeat (3) @(negedge clk);
    irq[2] = 1'b1;
    @(negedge clk);
    irq[2] = 1'b0;
    @(negedge clk);
    check("edge_e2", bus.mip_o, 32'h0);
    @(negedge clk);
    check("edge_e3", bus.mip_o, 32'h00040000);
    repeat (3) @(negedge clk);
    check("edge_held", bus.mip_o, 32'h00040000);
    csr(3'd3, 12'h344, 32'h00040000, 1'b0, 1'b0, r, ill);
    check("edge_clr_old", r, 32'h00040000);
    check("edge_clr", bus.mip_o, 32'h0);
    csr(3'd2, 12'h344, 32'h00040000, 1'b0, 1'b0, r, ill);
    check("edge_set_ign", bus.mip_o, 32'h0);
    irq[2] = 1'b1;
    @(negedge clk);
    irq[2] = 1'b0;
    @(negedge clk);
    csr(3'd3, 12'h344, 32'h00040000, 1'b0, 1'b0, r, ill);
    check("edge_set_wins", bus.mip_o, 32'h00040000);
    csr(3'd3, 12'h344, 32'h00040000, 1'b0, 1'b0, r, ill);
    check("edge_clr2", bus.mip_o, 32'h0);
    wr(12'h340, 32'hA5A51234);
    csr(3'd2, 12'h340, 32'h0, 1'b1, 1'b0, r, ill);
    check("rs_x0_old", r, 32'hA5A51234);
    rd_chk("rs_x0_nowr", 12'h340, 32'hA5A51234);
    csr(3'd1, 12'h340, 32'h11112222, 1'b0, 1'b1, r, ill);
    check("rw_rdzero", r, 32'h0);
    rd_chk("rw_rdzero_wr", 12'h340, 32'h11112222);
    csr(3'd1, 12'hF14, 32'h5, 1'b0, 1'b0, r, ill);
    check("hartid_wr_ill", 32'(ill), 32'd1);
    check("hartid_wr_rd", r, 32'h0);
    csr(3'd2, 12'hF14, 32'h0, 1'b1, 1'b0, r, ill);
    check("hartid_rd_ill", 32'(ill), 32'd0);
    csr(3'd1, 12'h7C0, 32'hDEAD, 1'b0, 1'b0, r, ill);
    check("unk_ill", 32'(ill), 32'd1);
    check("unk_rd", r, 32'h0);
    rd_chk("ill_nochg", 12'h340, 32'h11112222);
    wr(12'h305, 32'h12345672);
    rd_chk("mtvec_warl2", 12'h305, 32'h12345670);
    wr(12'h305, 32'h12345673);
    rd_chk("mtvec_warl3", 12'h305, 32'h12345670);
    wr(12'h305, 32'h12345671);
    rd_chk("mtvec_mode1", 12'h305, 32'h12345671);
    wr(12'h341, 32'h08000107);
    rd_chk("mepc_align", 12'h341, 32'h08000104);
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFFFFFF);
    @(negedge clk);
    rd_chk("mcycleh_wrap", 12'hB80, 32'h1);
    rd_chk("mcycle_wrap", 12'hB00, 32'h1);
    bus.retire_i = 1'b1;
    wr(12'hB02, 32'h5);
    repeat (7) @(negedge clk);
    bus.retire_i = 1'b0;
    rd_chk("minstret", 12'hB02, 32'd12);
    rd_chk("minstreth", 12'hB82, 32'h0);
    bus.csr_op_i = 3'd2;
    bus.csr_addr_i = 12'h305;
    bus.csr_wsrc_i = 32'h0;
    bus.csr_wsrc_zero_i = 1'b1;
    bus.csr_rd_zero_i = 1'b0;
    bus.csr_req_i = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_ack", 32'(bus.csr_ack_o), 32'd1);
    rst = 1'b1;
    bus.csr_req_i = 1'b0;
    #1;
    check("abort_ack", 32'(bus.csr_ack_o), 32'd0);
    check("abort_rdata", bus.csr_rdata_o, 32'h0);
    check("abort_vec", bus.trap_vec_o, 32'h08001000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst2_mtvec", 12'h305, 32'h08001000);
    rd_chk("rst2_mscratch", 12'h340, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_trap_csr_unit.md
Name: rv_trap_csr_unit

Overview:
- Parametrised machine-mode CSR and trap controller. It replaces the fixed 8-line, inline CSR/interrupt logic of the rv32 core with a standalone block.
- Owns mstatus/mie/mip/mtvec/mepc/mcause/mscratch, a 64-bit cycle counter and a 64-bit retired-instruction counter.
- Handles NUM_IRQ platform interrupt lines. Each line can be level- or edge-triggered.
- The core drives CSR instructions and trap events into it. It returns read data, the trap target PC and the interrupt request.

Parameters:
- NUM_IRQ, 8, number of platform interrupt lines (1..16). Line n maps to mip/mie bit 16+n.
- IRQ_EDGE_MASK, 16'h0000, per-line mode: bit n = 1 makes line n edge-triggered (rising); 0 makes it level.
- RESET_MTVEC, 32'h08001000, reset value of mtvec (direct mode).
- COUNTER_EN, 1, 1 implements mcycle/minstret. 0 makes them read as 0 and treats writes as illegal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock, reset is asynchronous and active-high
- irq_i  in  NUM_IRQ  asynchronous interrupt lines
- csr_req_i  in  1  one-cycle CSR instruction strobe
- csr_op_i  in  3  funct3 (1=RW 2=RS 3=RC 5=RWI 6=RSI 7=RCI)
- csr_addr_i  in  12  CSR address
- csr_wsrc_i  in  32  rs1 value, or zero-extended zimm
- csr_wsrc_zero_i  in  1  rs1 index / zimm is zero
- csr_rd_zero_i  in  1  rd is x0
- csr_ack_o  out  1  pulse one cycle after csr_req_i
- csr_rdata_o  out  32  old CSR value, valid with ack
- csr_illegal_o  out  1  valid with ack
- ecall_i, ebreak_i, mret_i  in  1 each  event strobes
- irq_take_i  in  1  core accepts the pending interrupt at an instruction boundary
- trap_pc_i  in  32  PC of the trapping or interrupted instruction
- retire_i  in  1  one instruction retired
- irq_req_o  out  1  an enabled interrupt is pending and mstatus.MIE=1
- wfi_wake_o  out  1  |(mip & mie), independent of MIE
- trap_valid_o  out  1  pulse one cycle after a take/ecall/ebreak/mret
- trap_vec_o  out  32  redirect PC, valid with trap_valid_o
- mip_o, mie_o  out  32  CSR mirrors

Behaviour:
- Reset (async, rst_i=1):
  - All CSRs are 0 except mtvec = RESET_MTVEC.
  - Synchronisers and pending bits are cleared.
  - Outputs: csr_ack_o=0, csr_illegal_o=0, trap_valid_o=0, csr_rdata_o=0, irq_req_o=0, wfi_wake_o=0, trap_vec_o=RESET_MTVEC.
  - A reset mid-operation aborts any pending ack or trap pulse.
- IRQ input path: each line has a 2-flop synchroniser (s1, s2) plus a delayed copy s3.
  - Level line: mip bit = s2, visible 2 edges after the irq_i change.
  - Edge line: pending is set when s2 & ~s3, visible 3 edges after the rise.
  - An edge pending bit clears when that line is taken, or on a CSR write of 0 to its mip bit. Writing 1 to it is ignored.
  - If set and clear happen in the same cycle, set wins.
  - Level mip bits are read-only.
- irq_req_o: combinational from registers, = MIE & |(mip & mie). Priority: the lowest line index wins.
- CSR access:
  - Write data: RW/RWI use wsrc; RS/RSI use old | wsrc; RC/RCI use old & ~wsrc.
  - No write occurs for RS/RC/RSI/RCI with csr_wsrc_zero_i=1.
  - Reads are side-effect free. csr_rd_zero_i only suppresses the read for RW/RWI, in which case rdata = 0.
  - The write commits on the same edge that raises ack.
- CSR register map:
  - mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; other bits 0.
  - mie 0x304: only bits 16..16+NUM_IRQ-1 writable.
  - mip 0x344: see the IRQ input path.
  - mtvec 0x305: bits [1:0] are WARL, so written values 2 or 3 store 00.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342, mscratch 0x340: full 32-bit R/W.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14: reads 0.
- Illegal CSR access: an unknown address, or a write attempt to mhartid, gives rdata = 0, no state change, and csr_illegal_o=1 with the ack.
- Counters:
  - mcycle increments every cycle; minstret increments on retire_i.
  - Both wrap 2^64-1 -> 0 with carry into the high word.
  - A CSR write to either half overrides the increment in that cycle.
- Trap events: the core asserts at most one per cycle. If several coincide, priority is irq_take > ecall > ebreak > mret > csr_req; the lower ones are dropped.
  - irq_take (only when irq_req_o=1, otherwise ignored):
    - mepc = trap_pc_i; mcause = {1, 31'(16+n)}.
    - MPIE = MIE, then MIE = 0.
    - trap_vec_o = base + 4*(16+n) if mtvec mode = 01, else base.
  - ecall: mcause = 11. ebreak: mcause = 3. For both, mepc = trap_pc_i, MPIE = MIE, MIE = 0, trap_vec_o = base (for any mode).
  - mret: MIE = MPIE, MPIE = 1, trap_vec_o = mepc.
  - Each event gives trap_valid_o for exactly 1 cycle on the following cycle.

Test Plan:
- Reset: release rst_i -> trap_vec_o=32'h08001000; read mtvec -> ack next cycle, rdata 32'h08001000; irq_req_o=0.
- Level IRQ: mie=32'h00010000, MIE=1, raise irq_i[0] -> irq_req_o high on the 2nd edge; irq_take_i with pc 32'h08000040 -> next cycle trap_valid_o=1, mcause=32'h80000010, mepc=32'h08000040, MIE=0, MPIE=1.
- Vectored and priority: mtvec=32'h08001001, irq 3 and irq 5 both pending and enabled -> take gives trap_vec_o=32'h08001000+4*19=32'h0800104C; mret -> trap_vec_o=mepc, MIE=1.
- Edge line (IRQ_EDGE_MASK bit 2): pulse irq_i[2] for 1 cycle with MIE=0 -> mip bit 18 set after 3 edges and held; csrrc clearing it -> 0; pulse again, set and clear in the same cycle -> stays 1.
- CSR semantics: csrrs mscratch with rs1=x0 -> no write, old value returned; csrrw to 0xF14 -> illegal=1, no change; csrrw to 0x7C0 -> illegal=1, rdata 0.
- Counter wrap and collision: write mcycle=32'hFFFFFFFF with mcycleh=0 -> after 1 cycle mcycleh=1; ecall together with irq_take -> only the interrupt is recorded (mcause MSB=1).
